best_arr_readout: RTL and testbench
===================================

BEST_ARR_READOUT -- requirements
Module: best_arr_readout

Interface
REQ-001 Parameter DATA_WIDTH, 11: output word width.
REQ-002 Parameter IDX_WIDTH, 9: stored best-index width; IDX_WIDTH <= DATA_WIDTH.
REQ-003 Parameter ROW_SIZE, 26: patches per image row.
REQ-004 Parameter COL_SIZE, 19: image rows.
REQ-005 Parameter NUM_SPLITS, 2: vertical strips; ROW_SIZE divisible by NUM_SPLITS; SPLIT_W = ROW_SIZE/NUM_SPLITS.
REQ-006 Parameter BLOCKING, 4: columns per block; NUM_BLK = ceil(SPLIT_W/BLOCKING); LAST_W = SPLIT_W-(NUM_BLK-1)*BLOCKING.
REQ-007 Parameter ADDRW, $clog2(ROW_SIZE*COL_SIZE): memory address width.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 rst  in  1  reset, asynchronous, active-high.
REQ-010 start  in  1  one-cycle request to begin a readout.
REQ-011 abort  in  1  synchronous cancel of a running readout.
REQ-012 raster_mode  in  1  0 = blocked order, 1 = raster order; sampled only with start.
REQ-013 mem_ren  out  1  read strobe to best-index memory.
REQ-014 mem_raddr  out  ADDRW  read address.
REQ-015 mem_rdata  in  IDX_WIDTH  read data, valid exactly 1 cycle after mem_ren.
REQ-016 out_wenq  out  1  push to output FIFO.
REQ-017 out_wdata  out  DATA_WIDTH  mem_rdata zero-extended.
REQ-018 out_wfull_n  in  1  output FIFO not full.
REQ-019 busy  out  1  high in STREAM and DRAIN.
REQ-020 done  out  1  one-cycle pulse on normal completion.

Function
REQ-021 FSM states IDLE, STREAM, DRAIN; IDLE->STREAM on start; STREAM->DRAIN after last read issued; DRAIN->IDLE when skid buffer and in-flight read are empty; done pulses in the cycle after that transition.
REQ-022 start while busy is ignored; start and abort in the same IDLE cycle: start wins, abort ignored.
REQ-023 Blocked order: nested loops p(0..NUM_SPLITS-1) > x(0..NUM_BLK-1) > y(0..COL_SIZE-1) > xi(0..w-1), w = LAST_W when x = NUM_BLK-1, else BLOCKING; address = p*SPLIT_W + y*ROW_SIZE + x*BLOCKING + xi.
REQ-024 Raster order: addresses 0..ROW_SIZE*COL_SIZE-1 ascending.
REQ-025 Each address read exactly once; total words = ROW_SIZE*COL_SIZE.
REQ-026 Address generation uses counters only: no multipliers; running row base is advanced by ROW_SIZE.
REQ-027 2-entry skid buffer; mem_ren asserted only when (buffered + in-flight) < 2, or == 2 with a push occurring this cycle.
REQ-028 out_wenq = buffer non-empty AND out_wfull_n; out_wdata = buffer head; order preserved.
REQ-029 Throughput 1 word/cycle while out_wfull_n = 1; first mem_ren in the cycle after start; first out_wenq 2 cycles after start.
REQ-030 out_wfull_n low: no push, head stable, address counters hold once the buffer is full; no word lost or duplicated.
REQ-031 abort while busy: next cycle IDLE, buffer and in-flight read discarded, counters cleared, no done pulse, no out_wenq from that cycle on.

Reset
REQ-032 rst asynchronously forces IDLE, clears counters and the buffer; mem_ren, out_wenq, busy, done = 0, mem_raddr = 0, out_wdata = 0.
REQ-033 rst mid-readout: same as REQ-032; the next start begins at the first address.

Verification
REQ-034 Defaults, blocked, out_wfull_n = 1, mem_rdata = address: pushes 0,1,2,3,26,27,28,29,...; block x=3 gives 12,38,...; strip 2 starts 13; 494 words; last 493; done 1 cycle after last push.
REQ-035 Defaults, raster_mode = 1: pushes 0..493 ascending, first push at start+2, done at start+496.
REQ-036 Random out_wfull_n (50%) in both modes: pushed sequence identical to REQ-034/035; no push while out_wfull_n = 0.
REQ-037 abort after 100 pushes: out_wenq 0 from the next cycle, busy 0, no done; a new start restarts at address 0.
REQ-038 rst asserted mid-stream between clock edges: outputs zero immediately; start while busy at word 50 has no effect.
REQ-039 ROW_SIZE=24, NUM_SPLITS=1, BLOCKING=8 (LAST_W=8) and BLOCKING=5 (LAST_W=4): address sequence matches REQ-023 formula.

Source files
------------

// File: rtl/best_arr_readout_if.sv
// rtl/best_arr_readout_if.sv - memory read port and output FIFO write port bundle
//
// master (readout engine): drives mem_ren, mem_raddr, out_wenq, out_wdata;
//                          receives mem_rdata, out_wfull_n
// slave  (memory + FIFO) : the reverse directions
interface best_arr_readout_if #(
    parameter int DATA_WIDTH = 11,
    parameter int IDX_WIDTH  = 9,
    parameter int ADDRW      = 9
);
    logic                  mem_ren;
    logic [ADDRW-1:0]      mem_raddr;
    logic [IDX_WIDTH-1:0]  mem_rdata;
    logic                  out_wenq;
    logic [DATA_WIDTH-1:0] out_wdata;
    logic                  out_wfull_n;

    modport master (
        output mem_ren, mem_raddr, out_wenq, out_wdata,
        input  mem_rdata, out_wfull_n
    );

    modport slave (
        input  mem_ren, mem_raddr, out_wenq, out_wdata,
        output mem_rdata, out_wfull_n
    );
endinterface

// File: rtl/best_arr_readout.sv
// rtl/best_arr_readout.sv - streams the best-index memory to an output FIFO in blocked or raster order
//
// Ports:
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   i_start         : one-cycle request to begin a readout (ignored while busy)
//   i_abort         : cancel a running readout
//   i_raster_mode   : 0 = blocked order, 1 = raster order (captured with i_start)
//   o_busy          : high while streaming or draining
//   o_done          : one-cycle pulse after normal completion
//   bus (master)    : memory read port (mem_ren/mem_raddr/mem_rdata, 1-cycle latency)
//                     and output FIFO write port (out_wenq/out_wdata/out_wfull_n)
module best_arr_readout #(
    parameter int DATA_WIDTH = 11,
    parameter int IDX_WIDTH  = 9,
    parameter int ROW_SIZE   = 26,
    parameter int COL_SIZE   = 19,
    parameter int NUM_SPLITS = 2,
    parameter int BLOCKING   = 4,
    parameter int ADDRW      = $clog2(ROW_SIZE*COL_SIZE)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_abort,
    input  logic i_raster_mode,
    output logic o_busy,
    output logic o_done,
    best_arr_readout_if.master bus
);
    localparam int SPLIT_W = ROW_SIZE / NUM_SPLITS;
    localparam int NUM_BLK = (SPLIT_W + BLOCKING - 1) / BLOCKING;
    localparam int LAST_W  = SPLIT_W - (NUM_BLK - 1) * BLOCKING;
    localparam int P_W     = $clog2(NUM_SPLITS + 1);
    localparam int X_W     = $clog2(NUM_BLK + 1);
    localparam int Y_W     = $clog2(COL_SIZE + 1);
    localparam int XI_W    = $clog2(ROW_SIZE + 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    state_t r_state;
    state_t w_state_next;

    logic              r_raster;
    logic [P_W-1:0]    r_p;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [XI_W-1:0]   r_xi;
    logic [ADDRW-1:0]  r_strip_base;
    logic [ADDRW-1:0]  r_blk_base;
    logic [ADDRW-1:0]  r_row_base;

    logic                 r_inflight;
    logic [1:0]           r_cnt;
    logic [IDX_WIDTH-1:0] r_buf0;
    logic [IDX_WIDTH-1:0] r_buf1;
    logic                 r_done;

    logic [XI_W-1:0]      w_width;
    logic                 w_last_xi, w_last_y, w_last_x, w_last_p, w_last_all;
    logic                 w_busy, w_abort_busy;
    logic [2:0]           w_occ, w_occ_next;
    logic                 w_head_valid, w_push, w_ren;
    logic                 w_pop_buf, w_ins;
    logic [1:0]           w_ins_pos;
    logic [IDX_WIDTH-1:0] w_head;
    logic                 w_done_set;

    // Raster order reuses the blocked loop nest as one strip of one block
    // whose width is the whole row, so a single set of counters serves both.
    assign w_width    = r_raster                         ? XI_W'(ROW_SIZE) :
                        (r_x == X_W'(NUM_BLK - 1))       ? XI_W'(LAST_W)   :
                                                           XI_W'(BLOCKING);
    assign w_last_xi  = (r_xi == w_width - XI_W'(1));
    assign w_last_y   = (r_y == Y_W'(COL_SIZE - 1));
    assign w_last_x   = r_raster || (r_x == X_W'(NUM_BLK - 1));
    assign w_last_p   = r_raster || (r_p == P_W'(NUM_SPLITS - 1));
    assign w_last_all = w_last_xi && w_last_y && w_last_x && w_last_p;

    assign w_busy       = (r_state != S_IDLE);
    assign w_abort_busy = w_busy && i_abort;

    // Data returning from memory this cycle can bypass straight to the FIFO
    // when nothing is buffered, giving the two-cycle start-to-push latency.
    assign w_head_valid = (r_cnt != 2'd0) || r_inflight;
    assign w_head       = (r_cnt != 2'd0) ? r_buf0 : bus.mem_rdata;
    assign w_push       = w_head_valid && bus.out_wfull_n && w_busy && !i_abort;

    assign w_occ      = {1'b0, r_cnt} + {2'b00, r_inflight};
    assign w_occ_next = w_occ - {2'b00, w_push};
    assign w_ren      = (r_state == S_STREAM) && !i_abort &&
                        ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_push));

    assign w_pop_buf = w_push && (r_cnt != 2'd0);
    assign w_ins     = r_inflight && !(w_push && (r_cnt == 2'd0));
    assign w_ins_pos = r_cnt - {1'b0, w_pop_buf};

    assign bus.mem_ren   = w_ren;
    assign bus.mem_raddr = r_row_base + ADDRW'(r_xi);
    assign bus.out_wenq  = w_push;
    assign bus.out_wdata = w_head_valid ? DATA_WIDTH'(w_head) : '0;
    assign o_busy        = w_busy;
    assign o_done        = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else if (w_ren && w_last_all) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave as soon as everything left is pushed this cycle so that
                // done lands one cycle after the final push.
                if (i_abort) begin
                    w_state_next = S_IDLE;
                end else if (w_occ_next == 3'd0) begin
                    w_state_next = S_IDLE;
                    w_done_set   = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raster     <= 1'b0;
            r_p          <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_xi         <= '0;
            r_strip_base <= '0;
            r_blk_base   <= '0;
            r_row_base   <= '0;
            r_inflight   <= 1'b0;
            r_cnt        <= 2'd0;
            r_buf0       <= '0;
            r_buf1       <= '0;
            r_done       <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_raster <= i_raster_mode;
            end

            if ((r_state == S_IDLE) || w_abort_busy) begin
                r_p          <= '0;
                r_x          <= '0;
                r_y          <= '0;
                r_xi         <= '0;
                r_strip_base <= '0;
                r_blk_base   <= '0;
                r_row_base   <= '0;
            end else if (w_ren) begin
                if (!w_last_xi) begin
                    r_xi <= r_xi + XI_W'(1);
                end else begin
                    r_xi <= '0;
                    if (!w_last_y) begin
                        r_y        <= r_y + Y_W'(1);
                        r_row_base <= r_row_base + ADDRW'(ROW_SIZE);
                    end else begin
                        r_y <= '0;
                        if (!w_last_x) begin
                            r_x        <= r_x + X_W'(1);
                            r_blk_base <= r_blk_base + ADDRW'(BLOCKING);
                            r_row_base <= r_blk_base + ADDRW'(BLOCKING);
                        end else begin
                            r_x <= '0;
                            if (!w_last_p) begin
                                r_p          <= r_p + P_W'(1);
                                r_strip_base <= r_strip_base + ADDRW'(SPLIT_W);
                                r_blk_base   <= r_strip_base + ADDRW'(SPLIT_W);
                                r_row_base   <= r_strip_base + ADDRW'(SPLIT_W);
                            end else begin
                                r_p          <= '0;
                                r_strip_base <= '0;
                                r_blk_base   <= '0;
                                r_row_base   <= '0;
                            end
                        end
                    end
                end
            end

            if (w_abort_busy) begin
                r_inflight <= 1'b0;
                r_cnt      <= 2'd0;
            end else begin
                r_inflight <= w_ren;
                if (w_pop_buf) begin
                    r_buf0 <= r_buf1;
                end
                // A later assignment to r_buf0 here overrides the shift above.
                if (w_ins) begin
                    if (w_ins_pos == 2'd0) begin
                        r_buf0 <= bus.mem_rdata;
                    end else begin
                        r_buf1 <= bus.mem_rdata;
                    end
                end
                r_cnt <= r_cnt - {1'b0, w_pop_buf} + {1'b0, w_ins};
            end

            r_done <= w_done_set;
        end
    end
endmodule

// File: tb/tb_best_arr_readout.sv
// tb/tb_best_arr_readout.sv - self-checking bench for best_arr_readout
module tb_best_arr_readout;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, raster0 = 1'b0;
    logic start2 = 1'b0, raster2 = 1'b0;
    logic abort = 1'b0;
    logic full_n = 1'b1;
    logic busy0, done0, busy8, done8, busy5, done5;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit stall_en = 1'b0;
    int stall_viol = 0;

    int push_q[$];
    int pcyc_q[$];
    int done_cnt = 0;
    int done_cyc = 0;
    int q8[$];
    int q5[$];
    int d8 = 0;
    int d5 = 0;
    int exp_q[$];
    int st_cyc = 0;

    always #5 clk = ~clk;

    best_arr_readout_if #(.DATA_WIDTH(11), .IDX_WIDTH(9), .ADDRW(9)) bus0 ();
    best_arr_readout_if #(.DATA_WIDTH(11), .IDX_WIDTH(9), .ADDRW(9)) bus8 ();
    best_arr_readout_if #(.DATA_WIDTH(11), .IDX_WIDTH(9), .ADDRW(9)) bus5 ();

    assign bus0.out_wfull_n = full_n;
    assign bus8.out_wfull_n = full_n;
    assign bus5.out_wfull_n = full_n;

    best_arr_readout u_dut (
        .clk(clk), .rst(rst), .i_start(start0), .i_abort(abort),
        .i_raster_mode(raster0), .o_busy(busy0), .o_done(done0), .bus(bus0)
    );

    best_arr_readout #(.ROW_SIZE(24), .NUM_SPLITS(1), .BLOCKING(8)) u_b8 (
        .clk(clk), .rst(rst), .i_start(start2), .i_abort(abort),
        .i_raster_mode(raster2), .o_busy(busy8), .o_done(done8), .bus(bus8)
    );

    best_arr_readout #(.ROW_SIZE(24), .NUM_SPLITS(1), .BLOCKING(5)) u_b5 (
        .clk(clk), .rst(rst), .i_start(start2), .i_abort(abort),
        .i_raster_mode(raster2), .o_busy(busy5), .o_done(done5), .bus(bus5)
    );

    // Memory holds its own address; data is garbage except the cycle after a read.
    always @(posedge clk) begin
        bus0.mem_rdata <= bus0.mem_ren ? bus0.mem_raddr : 9'($urandom);
        bus8.mem_rdata <= bus8.mem_ren ? bus8.mem_raddr : 9'($urandom);
        bus5.mem_rdata <= bus5.mem_ren ? bus5.mem_raddr : 9'($urandom);
    end

    always @(negedge clk) begin
        #2;
        if (bus0.out_wenq) begin
            push_q.push_back(int'(bus0.out_wdata));
            pcyc_q.push_back(cyc);
            if (!bus0.out_wfull_n) stall_viol++;
        end
        if (bus8.out_wenq) begin
            q8.push_back(int'(bus8.out_wdata));
            if (!bus8.out_wfull_n) stall_viol++;
        end
        if (bus5.out_wenq) begin
            q5.push_back(int'(bus5.out_wdata));
            if (!bus5.out_wfull_n) stall_viol++;
        end
        if (done0) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (done8) d8++;
        if (done5) d5++;
        cyc++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        full_n = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Reference order computed directly from the loop nest definition.
    task automatic build_model(input bit raster, input int row, input int col,
                               input int ns, input int blk);
        int sw, nb, lw, w;
        exp_q.delete();
        if (raster) begin
            for (int a = 0; a < row * col; a++) exp_q.push_back(a);
        end else begin
            sw = row / ns;
            nb = (sw + blk - 1) / blk;
            lw = sw - (nb - 1) * blk;
            for (int p = 0; p < ns; p++)
                for (int x = 0; x < nb; x++)
                    for (int y = 0; y < col; y++) begin
                        w = (x == nb - 1) ? lw : blk;
                        for (int xi = 0; xi < w; xi++)
                            exp_q.push_back(p * sw + y * row + x * blk + xi);
                    end
        end
    endtask

    function automatic int mism(input int got[$], input int ref_q[$]);
        int n;
        n = (got.size() > ref_q.size()) ? got.size() - ref_q.size() : ref_q.size() - got.size();
        for (int i = 0; i < got.size() && i < ref_q.size(); i++)
            if (got[i] != ref_q[i]) n++;
        return n;
    endfunction

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic clear_logs();
        push_q.delete();
        pcyc_q.delete();
        done_cnt = 0;
        done_cyc = 0;
        stall_viol = 0;
    endtask

    task automatic run0(input bit raster, input bit stall, input bit abort_too);
        clear_logs();
        stall_en = stall;
        tick();
        start0 = 1'b1;
        raster0 = raster;
        abort = abort_too;
        st_cyc = cyc;
        tick();
        start0 = 1'b0;
        abort = 1'b0;
        #2;
        check("busy_after_start", busy0, 1);
        check("ren_after_start", bus0.mem_ren, 1);
        check("raddr_first", bus0.mem_raddr, 0);
        for (int i = 0; i < 4000 && done_cnt == 0; i++) tick();
        tick();
        tick();
        stall_en = 1'b0;
    endtask

    typedef struct {
        bit raster;
        bit stall;
        bit abort_too;
        int exp_words;
        int exp_first;
        int exp_last;
        int exp_lat_push;
        int exp_lat_done;
    } scen_t;

    scen_t tbl[5];

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0, 494, 0, 493, 2, 496};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 494, 0, 493, 2, 496};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 494, 0, 493, -1, -1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 494, 0, 493, -1, -1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 494, 0, 493, 2, 496};

        // Reset state, both while held and after release.
        for (int k = 0; k < 2; k++) begin
            tick();
            tick();
            if (k == 1) rst = 1'b0;
            tick();
            #2;
            check("rst_busy", busy0, 0);
            check("rst_done", done0, 0);
            check("rst_ren", bus0.mem_ren, 0);
            check("rst_wenq", bus0.out_wenq, 0);
            check("rst_raddr", bus0.mem_raddr, 0);
            check("rst_wdata", bus0.out_wdata, 0);
        end

        for (int s = 0; s < 5; s++) begin
            run0(tbl[s].raster, tbl[s].stall, tbl[s].abort_too);
            build_model(tbl[s].raster, 26, 19, 2, 4);
            check($sformatf("s%0d_words", s), push_q.size(), tbl[s].exp_words);
            check($sformatf("s%0d_first", s), at(push_q, 0), tbl[s].exp_first);
            check($sformatf("s%0d_last", s), at(push_q, push_q.size() - 1), tbl[s].exp_last);
            check($sformatf("s%0d_seq_mism", s), mism(push_q, exp_q), 0);
            check($sformatf("s%0d_stall_viol", s), stall_viol, 0);
            check($sformatf("s%0d_done_cnt", s), done_cnt, 1);
            check($sformatf("s%0d_done_after_last", s),
                  done_cyc - at(pcyc_q, pcyc_q.size() - 1), 1);
            if (tbl[s].exp_lat_push >= 0) begin
                check($sformatf("s%0d_lat_push", s), at(pcyc_q, 0) - st_cyc, tbl[s].exp_lat_push);
                check($sformatf("s%0d_lat_done", s), done_cyc - st_cyc, tbl[s].exp_lat_done);
            end
            if (!tbl[s].raster) begin
                check($sformatf("s%0d_word4", s), at(push_q, 4), 26);
                check($sformatf("s%0d_blk3_start", s), at(push_q, 228), 12);
                check($sformatf("s%0d_strip2_start", s), at(push_q, 247), 13);
            end
            check($sformatf("s%0d_idle_busy", s), busy0, 0);
        end

        // Abort after 100 pushes, then restart from address 0.
        clear_logs();
        tick();
        start0 = 1'b1;
        raster0 = 1'b0;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 1000 && push_q.size() < 100; i++) tick();
        abort = 1'b1;
        #2;
        check("abort_cycle_wenq", bus0.out_wenq, 0);
        tick();
        abort = 1'b0;
        #2;
        check("abort_busy", busy0, 0);
        check("abort_ren", bus0.mem_ren, 0);
        check("abort_wenq", bus0.out_wenq, 0);
        for (int i = 0; i < 6; i++) tick();
        check("abort_pushes", push_q.size(), 100);
        check("abort_no_done", done_cnt, 0);
        run0(1'b0, 1'b0, 1'b0);
        build_model(1'b0, 26, 19, 2, 4);
        check("restart_first", at(push_q, 0), 0);
        check("restart_seq_mism", mism(push_q, exp_q), 0);

        // Start (with a different mode) while busy at word 50 is ignored.
        clear_logs();
        tick();
        start0 = 1'b1;
        raster0 = 1'b0;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 1000 && push_q.size() < 50; i++) tick();
        start0 = 1'b1;
        raster0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 4000 && done_cnt == 0; i++) tick();
        tick();
        tick();
        check("busy_start_seq_mism", mism(push_q, exp_q), 0);
        check("busy_start_done_cnt", done_cnt, 1);
        check("busy_start_idle", busy0, 0);

        // Reset between clock edges mid-stream, then a clean restart.
        clear_logs();
        tick();
        start0 = 1'b1;
        raster0 = 1'b0;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 1000 && push_q.size() < 120; i++) tick();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy0, 0);
        check("midrst_ren", bus0.mem_ren, 0);
        check("midrst_wenq", bus0.out_wenq, 0);
        check("midrst_raddr", bus0.mem_raddr, 0);
        check("midrst_wdata", bus0.out_wdata, 0);
        check("midrst_done", done0, 0);
        tick();
        rst = 1'b0;
        tick();
        run0(1'b0, 1'b1, 1'b0);
        check("after_rst_first", at(push_q, 0), 0);
        check("after_rst_seq_mism", mism(push_q, exp_q), 0);
        check("after_rst_done_cnt", done_cnt, 1);

        // Alternative geometries: 24-wide row, one strip, blocking 8 and 5.
        q8.delete();
        q5.delete();
        d8 = 0;
        d5 = 0;
        stall_viol = 0;
        stall_en = 1'b1;
        tick();
        start2 = 1'b1;
        raster2 = 1'b0;
        tick();
        start2 = 1'b0;
        for (int i = 0; i < 4000 && (d8 == 0 || d5 == 0); i++) tick();
        tick();
        stall_en = 1'b0;
        build_model(1'b0, 24, 19, 1, 8);
        check("b8_words", q8.size(), 456);
        check("b8_seq_mism", mism(q8, exp_q), 0);
        check("b8_done_cnt", d8, 1);
        build_model(1'b0, 24, 19, 1, 5);
        check("b5_words", q5.size(), 456);
        check("b5_seq_mism", mism(q5, exp_q), 0);
        check("b5_word4", at(q5, 4), 4);
        check("b5_word5", at(q5, 5), 24);
        check("b5_done_cnt", d5, 1);
        check("b_stall_viol", stall_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
